// File: rtl/wishbone_package.sv
// Shared widths, FSM state encoding and request/response payloads for the
// Wishbone master transactor.
package wishbone_package;

    localparam int unsigned REQ_ADDR_WIDTH = 32;
    localparam int unsigned WB_ADDR_WIDTH  = 10;
    localparam int unsigned WB_DATA_WIDTH  = 32;
    localparam int unsigned WB_SEL_WIDTH   = 4;
    localparam int unsigned TMO_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } xact_state_e;

    // Registered request as presented on the bus (word address)
    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] adr;
        logic                     we;
        logic [WB_SEL_WIDTH-1:0]  sel;
        logic [WB_DATA_WIDTH-1:0] dat;
    } wb_req_t;

    typedef struct packed {
        logic [WB_DATA_WIDTH-1:0] dat;
        logic                     err;
        logic                     tmo;
    } wb_rsp_t;

endpackage

// File: rtl/wb_xact_tmo_cnt.sv
// Bus-cycle watchdog: counts enabled cycles since clear and flags the cycle
// in which the limit-th sample without termination is taken.
module wb_xact_tmo_cnt
    import wishbone_package::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     enable_i,
    input  logic [TMO_CNT_WIDTH-1:0] limit_i,
    output logic                     expired_o
);

    logic [TMO_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     last_q, last_d;

    // last_q is precomputed so the expiry flag comes straight from a flop
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (clear_i) begin
            cnt_d  = '0;
            last_d = (limit_i == TMO_CNT_WIDTH'(1));
        end else if (enable_i) begin
            cnt_d  = TMO_CNT_WIDTH'(cnt_q + TMO_CNT_WIDTH'(1));
            last_d = (cnt_d == TMO_CNT_WIDTH'(limit_i - TMO_CNT_WIDTH'(1)));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign expired_o = last_q;

endmodule

// File: rtl/wb_master_xactor.sv
// Single-outstanding Wishbone classic master driven by a valid/ready request
// port; optional bus-cycle timeout enabled by WB_XACT_TIMEOUT_EN.
module wb_master_xactor
    import wishbone_package::*;
#(
    parameter int unsigned TMO_CYCLES = 256
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [REQ_ADDR_WIDTH-1:0] req_adr,
    input  logic                      req_we,
    input  logic [WB_SEL_WIDTH-1:0]   req_sel,
    input  logic [WB_DATA_WIDTH-1:0]  req_dat,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WB_DATA_WIDTH-1:0]  rsp_dat,
    output logic                      rsp_err,
    output logic                      rsp_tmo,
    output logic [WB_ADDR_WIDTH-1:0]  wb_adr_o,
    output logic [WB_DATA_WIDTH-1:0]  wb_dat_o,
    output logic [WB_SEL_WIDTH-1:0]   wb_sel_o,
    output logic                      wb_we_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    input  logic [WB_DATA_WIDTH-1:0]  wb_dat_i,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i
);

    if (TMO_CYCLES < 1 || TMO_CYCLES > 65535) begin : g_bad_tmo
        $error("wb_master_xactor: TMO_CYCLES must be 1..65535");
    end

    xact_state_e state_q, state_d;
    wb_req_t     req_q, req_d;
    wb_rsp_t     rsp_q, rsp_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        tmo_hit_c;
    logic        unused_adr_c;

    // Only the word offset within a 4 KiB window reaches the bus
    assign unused_adr_c = ^{req_adr[REQ_ADDR_WIDTH-1:WB_ADDR_WIDTH+2], req_adr[1:0]};

`ifdef WB_XACT_TIMEOUT_EN
    logic tmo_clear_c;
    logic tmo_en_c;

    assign tmo_clear_c = (state_q == ST_IDLE) && req_valid;
    assign tmo_en_c    = (state_q == ST_BUS) && !wb_ack_i && !wb_err_i;

    wb_xact_tmo_cnt u_tmo_cnt (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clear_i   (tmo_clear_c),
        .enable_i  (tmo_en_c),
        .limit_i   (TMO_CNT_WIDTH'(TMO_CYCLES)),
        .expired_o (tmo_hit_c)
    );
`else
    assign tmo_hit_c = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rsp_d   = rsp_q;
        we_d    = we_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d.adr = req_adr[WB_ADDR_WIDTH+1:2];
                    req_d.we  = req_we;
                    req_d.sel = req_sel;
                    req_d.dat = req_dat;
                    we_d      = req_we;
                    state_d   = ST_BUS;
                end
            end
            ST_BUS: begin
                // err beats ack; either beats a timeout in the same cycle
                if (wb_err_i) begin
                    rsp_d   = '{dat: '0, err: 1'b1, tmo: 1'b0};
                    state_d = ST_RSP;
                end else if (wb_ack_i) begin
                    rsp_d   = '{dat: (req_q.we ? '0 : wb_dat_i), err: 1'b0, tmo: 1'b0};
                    state_d = ST_RSP;
                end else if (tmo_hit_c) begin
                    rsp_d   = '{dat: '0, err: 1'b0, tmo: 1'b1};
                    state_d = ST_RSP;
                end
                if (state_d == ST_RSP) begin
                    we_d = 1'b0;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cyc_d       = (state_d == ST_BUS);
        ready_d     = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RSP);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            rsp_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_q       <= rsp_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_q.dat;
    assign rsp_err   = rsp_q.err;
    assign rsp_tmo   = rsp_q.tmo;
    assign wb_adr_o  = req_q.adr;
    assign wb_dat_o  = req_q.dat;
    assign wb_sel_o  = req_q.sel;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;

endmodule

// File: tb/tb_wb_master_xactor.sv
// Directed bench for wb_master_xactor: table of single transactions plus
// hand sequences for idle ack/err, timeout (WB_XACT_TIMEOUT_EN) and resets.
module tb_wb_master_xactor;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_adr, req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
    logic [31:0] rsp_dat;
    logic [9:0]  wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_master_xactor #(.TMO_CYCLES(TMO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_adr   (req_adr),
        .req_we    (req_we),
        .req_sel   (req_sel),
        .req_dat   (req_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .rsp_tmo   (rsp_tmo),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          wait_cyc;
        logic        ack;
        logic        err;
        logic [31:0] sdat;
        int          hold;
        logic [9:0]  exp_adr;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_req(input logic we, input logic [31:0] adr);
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_sel   = 4'hF;
        req_dat   = 32'h1111_2222;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cyc_cnt;
        int lat;
        int n;
        int bad;

        // write / read / ack+err / err-only / 3-wait read at top of window
        vecs[0] = '{we: 1'b1, adr: 32'h0000_0040, sel: 4'hF, dat: 32'hA5A5_0001, wait_cyc: 1,
                    ack: 1'b1, err: 1'b0, sdat: 32'hFFFF_FFFF, hold: 10,
                    exp_adr: 10'h010, exp_dat: 32'h0, exp_err: 1'b0};
        vecs[1] = '{we: 1'b0, adr: 32'h0000_0404, sel: 4'hF, dat: 32'h0, wait_cyc: 0,
                    ack: 1'b1, err: 1'b0, sdat: 32'h1234_5678, hold: 0,
                    exp_adr: 10'h101, exp_dat: 32'h1234_5678, exp_err: 1'b0};
        vecs[2] = '{we: 1'b0, adr: 32'h0000_0808, sel: 4'hC, dat: 32'h0, wait_cyc: 0,
                    ack: 1'b1, err: 1'b1, sdat: 32'hDEAD_BEEF, hold: 1,
                    exp_adr: 10'h202, exp_dat: 32'h0, exp_err: 1'b1};
        vecs[3] = '{we: 1'b1, adr: 32'hABCD_E7FE, sel: 4'h3, dat: 32'h0000_BEEF, wait_cyc: 2,
                    ack: 1'b0, err: 1'b1, sdat: 32'h5555_AAAA, hold: 0,
                    exp_adr: 10'h1FF, exp_dat: 32'h0, exp_err: 1'b1};
        vecs[4] = '{we: 1'b0, adr: 32'h0000_0FFC, sel: 4'h1, dat: 32'h0, wait_cyc: 3,
                    ack: 1'b1, err: 1'b0, sdat: 32'hCAFE_F00D, hold: 2,
                    exp_adr: 10'h3FF, exp_dat: 32'hCAFE_F00D, exp_err: 1'b0};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_sel = '0; req_dat = '0;
        rsp_ready = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_tmo", rsp_tmo, 0);
        chk("rst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        chk("rst_wb_adr", wb_adr_o, 0);
        chk("rst_wb_sel", wb_sel_o, 0);
        chk("rst_wb_dat", wb_dat_o, 0);
        rst = 1'b0;
        tick();

        // ack/err while idle must not start a response
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h7777_7777;
        tick();
        tick();
        chk("idle_ack_rsp_valid", rsp_valid, 0);
        chk("idle_ack_cyc", wb_cyc_o, 0);
        chk("idle_ack_req_ready", req_ready, 1);
        wb_ack_i = 1'b0; wb_err_i = 1'b0;

        for (int v = 0; v < NV; v++) begin
            req_valid = 1'b1; req_we = vecs[v].we; req_adr = vecs[v].adr;
            req_sel = vecs[v].sel; req_dat = vecs[v].dat; rsp_ready = 1'b0;
            chk("req_ready_idle", req_ready, 1);
            tick();
            // scramble request inputs: bus must use the registered copy
            req_valid = 1'b0; req_we = ~vecs[v].we; req_adr = ~vecs[v].adr;
            req_sel = ~vecs[v].sel; req_dat = ~vecs[v].dat;
            chk("accept_rsp_valid", rsp_valid, 0);
            chk("accept_req_ready", req_ready, 0);
            cyc_cnt = 0;
            lat = 0;
            for (int w = 0; w <= vecs[v].wait_cyc; w++) begin
                if (wb_cyc_o) cyc_cnt++;
                chk("bus_stb", wb_stb_o, 1);
                chk("bus_adr", wb_adr_o, vecs[v].exp_adr);
                chk("bus_we", wb_we_o, vecs[v].we);
                chk("bus_sel", wb_sel_o, vecs[v].sel);
                chk("bus_dat", wb_dat_o, vecs[v].dat);
                if (w == vecs[v].wait_cyc) begin
                    wb_ack_i = vecs[v].ack; wb_err_i = vecs[v].err; wb_dat_i = vecs[v].sdat;
                end
                tick();
                lat++;
            end
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0BAD_0BAD;
            chk("term_cyc_low", {wb_cyc_o, wb_stb_o}, 0);
            chk("cyc_cycles", cyc_cnt, vecs[v].wait_cyc + 1);
            // visible after the edge following termination, so a zero-wait
            // slave yields a handshake-able rsp_valid at the 2nd edge
            chk("rsp_latency", (rsp_valid ? lat : -1), vecs[v].wait_cyc + 1);
            chk("rsp_dat", rsp_dat, vecs[v].exp_dat);
            chk("rsp_err", rsp_err, vecs[v].exp_err);
            chk("rsp_tmo", rsp_tmo, 0);
            for (int h = 0; h < vecs[v].hold; h++) begin
                tick();
                chk("hold_rsp_valid", rsp_valid, 1);
                chk("hold_rsp_payload", {rsp_dat[30:0], rsp_err}, {vecs[v].exp_dat[30:0], vecs[v].exp_err});
            end
            rsp_ready = 1'b1;
            req_valid = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk("done_rsp_valid", rsp_valid, 0);
            chk("done_no_accept", wb_cyc_o, 0);
            req_valid = 1'b0;
            chk("done_req_ready", req_ready, 1);
            chk("idle_we", wb_we_o, 0);
            chk("idle_adr_held", wb_adr_o, vecs[v].exp_adr);
            chk("idle_sel_held", wb_sel_o, vecs[v].sel);
        end

        // silent slave
        start_req(1'b0, 32'h0000_0100);
`ifdef WB_XACT_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 20 && wb_cyc_o; i++) begin
            n++;
            tick();
        end
        chk("tmo_cyc_cycles", n, TMO);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_tmo", rsp_tmo, 1);
        chk("tmo_rsp_err", rsp_err, 0);
        chk("tmo_rsp_dat", rsp_dat, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("tmo_done", {rsp_valid, req_ready}, 2'b01);
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!wb_cyc_o || rsp_valid) bad++;
            tick();
        end
        chk("notmo_cyc_held", bad, 0);
        pulse_reset();
        chk("notmo_rst_cyc", wb_cyc_o, 0);
        chk("notmo_rst_state", {rsp_valid, req_ready}, 2'b01);
`endif

        // reset during a bus phase discards the transaction
        start_req(1'b0, 32'h0000_0200);
        tick();
        chk("midbus_cyc", wb_cyc_o, 1);
        pulse_reset();
        chk("midbus_rst_cyc", {wb_cyc_o, wb_stb_o}, 0);
        chk("midbus_rst_state", {rsp_valid, req_ready}, 2'b01);
        chk("midbus_rst_adr", wb_adr_o, 0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h9999_9999;
        tick();
        wb_ack_i = 1'b0;
        tick();
        chk("midbus_no_rsp", rsp_valid, 0);

        // reset while a response is pending
        start_req(1'b0, 32'h0000_0300);
        wb_ack_i = 1'b1; wb_dat_i = 32'h4242_4242;
        tick();
        wb_ack_i = 1'b0;
        chk("midrsp_valid", rsp_valid, 1);
        chk("midrsp_dat", rsp_dat, 32'h4242_4242);
        pulse_reset();
        chk("midrsp_rst_valid", rsp_valid, 0);
        chk("midrsp_rst_dat", rsp_dat, 0);
        chk("midrsp_rst_ready", req_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
